bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
//   Sits upstream of the seven-segment nibble decoders: it takes a binary value from the GPIO
//   word and produces one BCD nibble per digit, so the HEX digits display decimal.
//   Also produces a leading-zero blank mask and an overflow flag for out-of-range values.
// PARAMETERS
//   BIN_W   20  width of the binary input, in bits (>=4)
//   DIGITS  6   number of BCD output digits; digit 0 is the least significant
// PORTS
//   clk       in   1           system clock
//   reset_n   in   1           asynchronous, active-low reset
//   start     in   1           request conversion of bin; sampled only in IDLE
//   bin       in   BIN_W       binary operand; captured on the accepted start edge
//   busy      out  1           high while a conversion is in progress
//   valid     out  1           one-cycle pulse; bcd, blank and overflow are updated
//   bcd       out  4*DIGITS    result; digit i is at [4i+3:4i]; held until the next completion
//   blank     out  DIGITS      1 = digit is a leading zero and must be blanked
//   overflow  out  1           last result exceeded 10^DIGITS-1; held with bcd
// BEHAVIOUR
//   Reset values: busy=0, valid=0, bcd=0, blank={DIGITS-1{1},1'b0}, overflow=0, state=IDLE.
//   Clocking: one clock only, clk. reset_n is asynchronous and active-low.
//   States: IDLE, SHIFT.
//   IDLE:  on an edge with start=1:
//     - capture bin into the shift register; clear the BCD scratch, the sticky overflow and cnt
//     - go to SHIFT; busy=1 from the next cycle
//   SHIFT: each edge performs one iteration, then cnt++:
//     - every scratch digit >=5 gets +3
//     - shift {scratch, binreg} left by 1
//     - a 1 shifted out of the top digit sets the sticky overflow
//   Completion, on the edge of the BIN_W-th shift:
//     - bcd <= scratch; overflow <= sticky
//     - if sticky=1, bcd <= all digits 9 (saturate)
//     - blank recomputed; valid=1 for exactly one cycle; busy=0; state=IDLE
//   Latency: start sampled at edge 0 -> valid high after edge BIN_W.
//     The next start is accepted at that same edge (back-to-back), giving BIN_W cycles/result.
//   start while busy=1: ignored; no queueing; the in-flight conversion is not disturbed.
//   bin is don't-care except on the accepted start edge.
//   blank[i] = 1 iff digits i..DIGITS-1 of the final bcd are all 0, for i>=1; blank[0] is always 0.
//     On overflow, blank = 0.
//   Add-3 is applied only to digits, never to binreg bits.
//     Each digit stays <=9 after every shift when no overflow occurs.
//   reset_n low mid-conversion: abort immediately; all outputs return to reset values.
//     No valid pulse for the aborted conversion.
//   When BIN_W < 4*DIGITS*log2(10)/4, overflow can never occur; the logic remains in place regardless.
// TESTING (defaults BIN_W=20, DIGITS=6)
//   1. reset, bin=0, start pulse
//      -> valid after 20 edges, bcd=24'h000000, blank=6'b111110, overflow=0
//   2. bin=20'h1E240 (123456)
//      -> bcd=24'h123456, blank=0, overflow=0; busy high for exactly 20 cycles
//   3. bin=20'hF423F (999999) -> bcd=24'h999999, overflow=0
//      bin=20'hF4240 (1000000) -> bcd=24'h999999, overflow=1
//   4. bin=20'h00309 (777) -> bcd=24'h000777, blank=6'b111000
//      start with bin=5 during busy -> ignored; result is still 777
//   5. start held high continuously with bin=1, then 2
//      -> valid every 20 cycles, results 000001 then 000002
//   6. reset_n low at cycle 10 of a conversion -> outputs at reset values, no valid;
//      next start converts correctly

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using iterative double-dabble
// (shift-and-add-3). A conversion takes BIN_W clock cycles, one iteration per
// cycle. The result feeds the seven-segment nibble decoders. The converter
// also produces a leading-zero blank mask and an overflow flag. Values above
// 10^DIGITS-1 saturate to all nines.
//
// Parameters
//   BIN_W       width of the binary operand (>= 4)
//   DIGITS      number of BCD digits; digit 0 is the least significant
//
// Ports
//   i_clk       system clock
//   i_reset_n   asynchronous, active-low reset
//   i_start     conversion request; sampled only when no conversion is running
//               (also on the completion edge, which allows back-to-back runs)
//   i_bin       binary operand; captured on the accepted start edge
//   o_busy      high while a conversion is in progress
//   o_valid     one-cycle pulse when o_bcd/o_blank/o_overflow are updated
//   o_bcd       result; digit i is at [4i+3:4i]; held until the next completion
//   o_blank     1 = digit is a leading zero (bit 0 is always 0)
//   o_overflow  last result exceeded 10^DIGITS-1; held with o_bcd
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t             r_state,    w_state_next;
    logic [BIN_W-1:0]   r_binreg,   w_binreg_next;
    logic [BCD_W-1:0]   r_scratch,  w_scratch_next;
    logic               r_sticky,   w_sticky_next;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_next;
    logic [BCD_W-1:0]   r_bcd,      w_bcd_next;
    logic [DIGITS-1:0]  r_blank,    w_blank_next;
    logic               r_overflow, w_overflow_next;
    logic               r_valid,    w_valid_next;

    // -------------------------------------------------------------------------
    // One double-dabble iteration
    // -------------------------------------------------------------------------
    logic [BCD_W-1:0]   w_adj;          // scratch after per-digit add-3
    logic [BCD_W-1:0]   w_shifted;      // scratch after the left shift
    logic [BIN_W-1:0]   w_binreg_shl;   // binary register after the left shift
    logic               w_carry_out;    // bit leaving the top digit this iteration
    logic               w_last;         // this edge performs the BIN_W-th shift
    logic               w_final_ovf;
    logic [BCD_W-1:0]   w_all_nines;
    logic [BCD_W-1:0]   w_final_bcd;
    logic [DIGITS-1:0]  w_final_blank;
    logic [DIGITS:1]    w_upper_zero;   // [i] = digits i..DIGITS-1 of the result are 0

    // Add-3 touches only the BCD digits, never the binary register bits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                    ? r_scratch[4*gi +: 4] + 4'd3
                                    : r_scratch[4*gi +: 4];
            assign w_all_nines[4*gi +: 4] = 4'd9;
        end
    endgenerate

    assign w_carry_out  = w_adj[BCD_W-1];
    assign w_shifted    = {w_adj[BCD_W-2:0], r_binreg[BIN_W-1]};
    assign w_binreg_shl = {r_binreg[BIN_W-2:0], 1'b0};
    assign w_last       = (r_cnt == CNT_W'(BIN_W - 1));

    // The carry of the final iteration is folded in here because the sticky
    // register only sees it one edge later.
    assign w_final_ovf  = r_sticky | w_carry_out;
    assign w_final_bcd  = w_final_ovf ? w_all_nines : w_shifted;

    // Leading-zero mask, built as a chain from the most significant digit down.
    // Digit 0 is never blanked so a zero result still shows a single "0".
    assign w_upper_zero[DIGITS] = 1'b1;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_upper_zero[gi] = w_upper_zero[gi+1]
                                    & (w_final_bcd[4*gi +: 4] == 4'd0);
            assign w_final_blank[gi] = w_upper_zero[gi] & ~w_final_ovf;
        end
    endgenerate
    assign w_final_blank[0] = 1'b0;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_binreg_next   = r_binreg;
        w_scratch_next  = r_scratch;
        w_sticky_next   = r_sticky;
        w_cnt_next      = r_cnt;
        w_bcd_next      = r_bcd;
        w_blank_next    = r_blank;
        w_overflow_next = r_overflow;
        w_valid_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_binreg_next  = i_bin;
                    w_scratch_next = '0;
                    w_sticky_next  = 1'b0;
                    w_cnt_next     = '0;
                    w_state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_scratch_next = w_shifted;
                w_binreg_next  = w_binreg_shl;
                w_sticky_next  = r_sticky | w_carry_out;
                w_cnt_next     = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_bcd_next      = w_final_bcd;
                    w_overflow_next = w_final_ovf;
                    w_blank_next    = w_final_blank;
                    w_valid_next    = 1'b1;
                    w_state_next    = ST_IDLE;
                    // A start on the completion edge is accepted right away,
                    // so a held start yields one result every BIN_W cycles.
                    if (i_start) begin
                        w_binreg_next  = i_bin;
                        w_scratch_next = '0;
                        w_sticky_next  = 1'b0;
                        w_cnt_next     = '0;
                        w_state_next   = ST_SHIFT;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_binreg   <= '0;
            r_scratch  <= '0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_binreg   <= w_binreg_next;
            r_scratch  <= w_scratch_next;
            r_sticky   <= w_sticky_next;
            r_cnt      <= w_cnt_next;
            r_bcd      <= w_bcd_next;
            r_blank    <= w_blank_next;
            r_overflow <= w_overflow_next;
            r_valid    <= w_valid_next;
        end
    end

    assign o_busy     = (r_state == ST_SHIFT);
    assign o_valid    = r_valid;
    assign o_bcd      = r_bcd;
    assign o_blank    = r_blank;
    assign o_overflow = r_overflow;

endmodule
